// File: rtl/fsub_seq.sv
// ---------------------------------------------------------------------------
// fsub_seq -- multi-cycle IEEE-754 single-precision subtractor (out = a - b)
//
// Denormal inputs are treated as zero, rounding is truncation, and results
// that would become denormal are flushed to signed zero. Any operand with an
// all-ones exponent (Inf/NaN) produces the canonical quiet NaN with inv=1.
//
// Ports
//   clk    input   1   clock, rising edge
//   rst    input   1   asynchronous active-high reset
//   start  input   1   request, sampled only while idle
//   a      input  32   minuend (captured on the accepting edge)
//   b      input  32   subtrahend (captured on the accepting edge)
//   out    output 32   result, valid while done=1, held until next result
//   busy   output  1   high whenever the FSM is not idle
//   done   output  1   one-cycle completion pulse
//   ovf    output  1   result overflowed to infinity
//   inv    output  1   an operand was Inf/NaN
//
// Latency: done rises 5+k edges after the accepting edge, where k is the
// number of normalisation left shifts (2 edges for the Inf/NaN path).
// ---------------------------------------------------------------------------
module fsub_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] out,
  output logic        busy,
  output logic        done,
  output logic        ovf,
  output logic        inv
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_UNPACK = 3'd1,
    S_ALIGN  = 3'd2,
    S_ADD    = 3'd3,
    S_NORM   = 3'd4,
    S_PACK   = 3'd5
  } state_t;

  localparam logic [31:0] QNAN_WORD = 32'h7FC0_0000;

  // Assemble a result word from sign, biased exponent and fraction bits.
  function automatic logic [31:0] pack_word(input logic       s,
                                            input logic [7:0] e,
                                            input logic [22:0] f);
    return {s, e, f};
  endfunction

  // Expand a biased exponent/fraction pair into a 27-bit mantissa with the
  // hidden bit at position 26 and three guard bits below the fraction.
  // A zero exponent means zero (no denormal support).
  function automatic logic [26:0] unpack_mant(input logic [7:0]  e,
                                              input logic [22:0] f);
    logic [26:0] m;
    if (e == 8'd0) begin
      m = 27'd0;
    end else begin
      m = {1'b1, f, 3'b000};
    end
    return m;
  endfunction

  // ---------------------------------------------------------------- state
  state_t      state_q;
  logic [31:0] a_q, b_q;         // captured operands
  logic        inv_pend_q;       // Inf/NaN seen during unpack
  logic        big_s_q, sml_s_q; // effective signs (b already negated)
  logic [8:0]  big_e_q;          // exponent of the larger magnitude
  logic [7:0]  diff_q;           // exponent difference big - small
  logic [26:0] big_m_q, sml_m_q; // mantissas, sml_m_q aligned after ALIGN
  logic        zero_both_q;      // both operands were zero
  logic        zero_sign_q;      // sign of a zero-minus-zero result
  logic [26:0] res_m_q;          // working result mantissa
  logic [8:0]  res_e_q;          // working result exponent (9b for overflow)
  logic        res_s_q;          // working result sign
  logic [31:0] out_q;
  logic        busy_q, done_q, ovf_q, inv_q;

  // ------------------------------------------------------ combinational next
  logic [7:0]  ea_d, eb_d;
  logic [26:0] ma_d, mb_d;
  logic        sa_d, sb_d;
  logic        nan_in_d;
  logic        a_big_d;
  logic [26:0] aligned_d;
  logic        same_sign_d;
  logic [27:0] sum_d;

  // Unpack the captured operands and pick the larger magnitude.
  always_comb begin
    ea_d     = a_q[30:23];
    eb_d     = b_q[30:23];
    ma_d     = unpack_mant(ea_d, a_q[22:0]);
    mb_d     = unpack_mant(eb_d, b_q[22:0]);
    sa_d     = a_q[31];
    sb_d     = ~b_q[31];   // subtraction is addition of -b
    nan_in_d = (ea_d == 8'hFF) || (eb_d == 8'hFF);
    // Ties keep a as the larger operand; zero operands have zero mantissa
    // so the concatenated compare orders them correctly.
    a_big_d  = ({ea_d, ma_d} >= {eb_d, mb_d});
  end

  // Alignment shifter and effective add/subtract.
  always_comb begin
    if (diff_q >= 8'd27) begin
      aligned_d = 27'd0;
    end else begin
      aligned_d = sml_m_q >> diff_q;
    end
    same_sign_d = (big_s_q == sml_s_q);
    if (same_sign_d) begin
      sum_d = {1'b0, big_m_q} + {1'b0, sml_m_q};
    end else begin
      // big >= small by construction, so no borrow out
      sum_d = {1'b0, big_m_q} - {1'b0, sml_m_q};
    end
  end

  // Main FSM: datapath registers and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      a_q         <= 32'd0;
      b_q         <= 32'd0;
      inv_pend_q  <= 1'b0;
      big_s_q     <= 1'b0;
      sml_s_q     <= 1'b0;
      big_e_q     <= 9'd0;
      diff_q      <= 8'd0;
      big_m_q     <= 27'd0;
      sml_m_q     <= 27'd0;
      zero_both_q <= 1'b0;
      zero_sign_q <= 1'b0;
      res_m_q     <= 27'd0;
      res_e_q     <= 9'd0;
      res_s_q     <= 1'b0;
      out_q       <= 32'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
      inv_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            a_q        <= a;
            b_q        <= b;
            inv_pend_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= S_UNPACK;
          end else begin
            busy_q     <= 1'b0;
            state_q    <= S_IDLE;
          end
        end

        S_UNPACK: begin
          zero_both_q <= (ea_d == 8'd0) && (eb_d == 8'd0);
          zero_sign_q <= a_q[31] & ~b_q[31];
          if (nan_in_d) begin
            inv_pend_q <= 1'b1;
            state_q    <= S_PACK;
          end else begin
            inv_pend_q <= 1'b0;
            if (a_big_d) begin
              big_s_q <= sa_d;
              big_e_q <= {1'b0, ea_d};
              big_m_q <= ma_d;
              sml_s_q <= sb_d;
              sml_m_q <= mb_d;
              diff_q  <= ea_d - eb_d;
            end else begin
              big_s_q <= sb_d;
              big_e_q <= {1'b0, eb_d};
              big_m_q <= mb_d;
              sml_s_q <= sa_d;
              sml_m_q <= ma_d;
              diff_q  <= eb_d - ea_d;
            end
            state_q <= S_ALIGN;
          end
        end

        S_ALIGN: begin
          sml_m_q <= aligned_d;
          state_q <= S_ADD;
        end

        S_ADD: begin
          if (sum_d[27]) begin
            // carry out: renormalise right by one, dropping the LSB
            res_m_q <= sum_d[27:1];
            res_e_q <= big_e_q + 9'd1;
          end else begin
            res_m_q <= sum_d[26:0];
            res_e_q <= big_e_q;
          end
          if (sum_d == 28'd0) begin
            // exact cancellation is +0; only 0 - 0 keeps a signed zero
            res_s_q <= zero_both_q ? zero_sign_q : 1'b0;
          end else begin
            res_s_q <= big_s_q;
          end
          state_q <= S_NORM;
        end

        S_NORM: begin
          if (res_m_q[26] || (res_m_q == 27'd0)) begin
            state_q <= S_PACK;
          end else if (res_e_q <= 9'd1) begin
            // another shift would need exponent 0: flush to signed zero
            res_m_q <= 27'd0;
            state_q <= S_PACK;
          end else begin
            res_m_q <= {res_m_q[25:0], 1'b0};
            res_e_q <= res_e_q - 9'd1;
            state_q <= S_NORM;
          end
        end

        S_PACK: begin
          if (inv_pend_q) begin
            out_q <= QNAN_WORD;
            ovf_q <= 1'b0;
            inv_q <= 1'b1;
          end else if (res_m_q == 27'd0) begin
            out_q <= pack_word(res_s_q, 8'd0, 23'd0);
            ovf_q <= 1'b0;
            inv_q <= 1'b0;
          end else if (res_e_q >= 9'd255) begin
            out_q <= pack_word(res_s_q, 8'hFF, 23'd0);
            ovf_q <= 1'b1;
            inv_q <= 1'b0;
          end else begin
            // truncation: guard bits [2:0] are simply dropped
            out_q <= pack_word(res_s_q, res_e_q[7:0], res_m_q[25:3]);
            ovf_q <= 1'b0;
            inv_q <= 1'b0;
          end
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign out  = out_q;
  assign busy = busy_q;
  assign done = done_q;
  assign ovf  = ovf_q;
  assign inv  = inv_q;

endmodule

// File: tb/tb_fsub_seq.sv
// Self-checking bench for fsub_seq: directed vectors, randomized operands
// against an arithmetic reference model, back-to-back issue, ignored start
// while busy, and asynchronous reset abort.
module tb_fsub_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_in;
  logic [31:0] a_in, b_in;
  logic [31:0] out;
  logic        busy, done, ovf, inv;

  int cnt   = 0;
  int fails = 0;

  fsub_seq dut (
    .clk   (clk),
    .rst   (rst),
    .start (start_in),
    .a     (a_in),
    .b     (b_in),
    .out   (out),
    .busy  (busy),
    .done  (done),
    .ovf   (ovf),
    .inv   (inv)
  );

  always #5 clk = ~clk;

  // Reference model: a - b with no denormals, truncation, flush-to-zero.
  // Mantissas carry 3 guard bits below the 23 fraction bits.
  function automatic void model(input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] o, output logic ov,
                                output logic iv, output int lat);
    int     ex, ey, el, es, d, e, lz;
    longint mx, my, ml, ms, al, r, t;
    logic   sx, sy, sl, ss, s;
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    mx = (ex == 0) ? 64'd0 : longint'({1'b1, x[22:0]});
    my = (ey == 0) ? 64'd0 : longint'({1'b1, y[22:0]});
    sx = x[31];
    sy = ~y[31];
    ov = 1'b0;
    iv = 1'b0;
    if (ex == 255 || ey == 255) begin
      o = 32'h7FC0_0000; iv = 1'b1; lat = 2;
      return;
    end
    if (ex > ey || (ex == ey && mx >= my)) begin
      el = ex; ml = mx; sl = sx; es = ey; ms = my; ss = sy;
    end else begin
      el = ey; ml = my; sl = sy; es = ex; ms = mx; ss = sx;
    end
    d  = el - es;
    al = (d >= 27) ? 64'd0 : ((ms * 8) >> d);
    r  = (sl == ss) ? (ml * 8 + al) : (ml * 8 - al);
    e  = el;
    s  = sl;
    lat = 5;
    if (r == 0) begin
      s = (mx == 0 && my == 0) ? (x[31] & ~y[31]) : 1'b0;
      o = {s, 31'd0};
      return;
    end
    if (r >= 64'd134217728) begin  // 2^27
      r = r / 2;
      e = e + 1;
    end
    t = r; lz = 0;
    while (t < 64'd67108864) begin  // 2^26
      t = t * 2; lz++;
    end
    if (lz > e - 1) begin
      lat = 5 + (e - 1);
      o = {s, 31'd0};
      return;
    end
    lat = 5 + lz;
    e   = e - lz;
    if (e >= 255) begin
      o = {s, 8'hFF, 23'd0}; ov = 1'b1;
      return;
    end
    o = {s, 8'(e), 23'((t >> 3) & 64'h7F_FFFF)};
  endfunction

  // Drive one request and wait (bounded) for done; no checking here.
  task automatic issue_op(input logic [31:0] x, input logic [31:0] y,
                          output logic [31:0] o, output logic ov,
                          output logic iv, output int lat,
                          output logic busy_ok);
    a_in = x; b_in = y; start_in = 1'b1;
    @(posedge clk); #1;
    start_in = 1'b0;
    lat = 0; busy_ok = 1'b1;
    while (done !== 1'b1 && lat < 100) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    if (busy !== 1'b0) busy_ok = 1'b0;
    o = out; ov = ovf; iv = inv;
  endtask

  task automatic test_reset();
    rst = 1'b1; start_in = 1'b0; a_in = 32'd0; b_in = 32'd0;
    #3;
    cnt++;
    if ({out, busy, done, ovf, inv} !== 36'd0) begin
      fails++;
      $display("FAIL reset_state: got out=%h busy=%b done=%b ovf=%b inv=%b, want all zero",
               out, busy, done, ovf, inv);
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [31:0] va [8] = '{32'h4000_0000, 32'h4040_0000, 32'h3F80_0000, 32'h3F80_0000,
                            32'h7F7F_FFFF, 32'h7F80_0000, 32'h8000_0000, 32'h0000_0000};
    logic [31:0] vb [8] = '{32'h3F80_0000, 32'hBFC0_0000, 32'h3F7F_FFFF, 32'h3F80_0000,
                            32'hFF7F_FFFF, 32'h1234_5678, 32'h0000_0000, 32'h8000_0000};
    logic [31:0] vo [8] = '{32'h3F80_0000, 32'h4090_0000, 32'h3380_0000, 32'h0000_0000,
                            32'h7F80_0000, 32'h7FC0_0000, 32'h8000_0000, 32'h0000_0000};
    logic        vv [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic        vi [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    int          vl [8] = '{6, 5, 29, 5, 5, 2, 5, 5};
    logic [31:0] o; logic ov, iv, bok; int lat;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      issue_op(va[i], vb[i], o, ov, iv, lat, bok);
      cnt++;
      if (o !== vo[i] || ov !== vv[i] || iv !== vi[i]) begin
        fails++;
        $display("FAIL directed_%0d result: got out=%h ovf=%b inv=%b, want out=%h ovf=%b inv=%b",
                 i, o, ov, iv, vo[i], vv[i], vi[i]);
      end
      cnt++;
      if (lat !== vl[i] || bok !== 1'b1) begin
        fails++;
        $display("FAIL directed_%0d timing: got latency=%0d busy_ok=%b, want latency=%0d busy_ok=1",
                 i, lat, bok, vl[i]);
      end
      @(posedge clk); #1;
      cnt++;
      if (done !== 1'b0) begin
        fails++;
        $display("FAIL directed_%0d done_pulse: got done=%b one cycle later, want 0", i, done);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] x, y, eo, o; logic eov, eiv, ov, iv, bok; int el, lat;
    int sel;
    for (int i = 0; i < 300; i++) begin
      x = $urandom; y = $urandom;
      sel = $urandom_range(0, 9);
      case (sel)
        0: y[30:23] = x[30:23];
        1: begin y[30:23] = x[30:23] + 8'd1; y[31] = x[31]; end
        2: begin x[30:23] = 8'($urandom_range(1, 3)); y = x ^ 32'($urandom_range(1, 255)); end
        3: if ($urandom_range(0, 1) == 0) x[30:23] = 8'hFF; else y[30:23] = 8'hFF;
        4: begin x[30:23] = 8'd0; if ($urandom_range(0, 1) == 0) y[30:23] = 8'd0; end
        5: y = x ^ 32'($urandom_range(1, 15));
        6: begin x[30:23] = 8'd254; y[30:23] = 8'd254 - 8'($urandom_range(0, 2)); y[31] = ~x[31]; end
        7: begin y[30:23] = x[30:23] - 8'($urandom_range(20, 30)); end
        default: ;
      endcase
      model(x, y, eo, eov, eiv, el);
      @(negedge clk);
      issue_op(x, y, o, ov, iv, lat, bok);
      cnt++;
      if (o !== eo || ov !== eov || iv !== eiv || lat !== el || bok !== 1'b1) begin
        fails++;
        $display("FAIL random_%0d a=%h b=%h: got out=%h ovf=%b inv=%b lat=%0d busy_ok=%b, want out=%h ovf=%b inv=%b lat=%0d",
                 i, x, y, o, ov, iv, lat, bok, eo, eov, eiv, el);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] xs [3] = '{32'h3F80_0000, 32'h4120_0000, 32'hC0A0_0000};
    logic [31:0] ys [3] = '{32'h3F7F_FFFF, 32'h3E80_0000, 32'h40A0_0001};
    logic [31:0] eo, o; logic eov, eiv, ov, iv, bok; int el, lat;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      // issued immediately in the previous done cycle
      model(xs[i], ys[i], eo, eov, eiv, el);
      issue_op(xs[i], ys[i], o, ov, iv, lat, bok);
      cnt++;
      if (o !== eo || ov !== eov || iv !== eiv || lat !== el) begin
        fails++;
        $display("FAIL back_to_back_%0d: got out=%h ovf=%b inv=%b lat=%0d, want out=%h ovf=%b inv=%b lat=%0d",
                 i, o, ov, iv, lat, eo, eov, eiv, el);
      end
    end
    repeat (4) @(posedge clk);
    #1;
    cnt++;
    if (out !== eo || ovf !== eov || inv !== eiv || busy !== 1'b0) begin
      fails++;
      $display("FAIL hold_result: got out=%h ovf=%b inv=%b busy=%b, want out=%h ovf=%b inv=%b busy=0",
               out, ovf, inv, busy, eo, eov, eiv);
    end
  endtask

  task automatic test_ignore_start();
    logic [31:0] eo; logic eov, eiv; int el, lat; logic spurious;
    model(32'h3F80_0000, 32'h3F7F_FFFF, eo, eov, eiv, el);
    @(negedge clk);
    a_in = 32'h3F80_0000; b_in = 32'h3F7F_FFFF; start_in = 1'b1;
    @(posedge clk); #1;
    // keep start high with different operands while busy
    a_in = 32'h7F80_0000; b_in = 32'h4000_0000;
    lat = 0;
    while (done !== 1'b1 && lat < 100) begin
      if (lat == 3) start_in = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    start_in = 1'b0;
    cnt++;
    if (out !== eo || inv !== eiv || lat !== el) begin
      fails++;
      $display("FAIL ignore_start: got out=%h inv=%b lat=%0d, want out=%h inv=%b lat=%0d",
               out, inv, lat, eo, eiv, el);
    end
    spurious = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (busy !== 1'b0) spurious = 1'b1;
    end
    cnt++;
    if (spurious !== 1'b0) begin
      fails++;
      $display("FAIL ignore_start_idle: got busy seen=%b after done, want 0", spurious);
    end
  endtask

  task automatic test_reset_abort();
    logic [31:0] o; logic ov, iv, bok; int lat; logic seen;
    @(negedge clk);
    a_in = 32'h3F80_0000; b_in = 32'h3F7F_FFFF; start_in = 1'b1;
    @(posedge clk); #1;
    start_in = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    cnt++;
    if (busy !== 1'b0 || done !== 1'b0 || out !== 32'd0 || ovf !== 1'b0 || inv !== 1'b0) begin
      fails++;
      $display("FAIL reset_abort_state: got busy=%b done=%b out=%h ovf=%b inv=%b, want all zero",
               busy, done, out, ovf, inv);
    end
    #3 rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    cnt++;
    if (seen !== 1'b0) begin
      fails++;
      $display("FAIL reset_abort_done: got activity=%b after reset, want 0", seen);
    end
    @(negedge clk);
    issue_op(32'h4000_0000, 32'h3F80_0000, o, ov, iv, lat, bok);
    cnt++;
    if (o !== 32'h3F80_0000 || ov !== 1'b0 || iv !== 1'b0 || lat !== 6) begin
      fails++;
      $display("FAIL reset_recover: got out=%h ovf=%b inv=%b lat=%0d, want out=3f800000 ovf=0 inv=0 lat=6",
               o, ov, iv, lat);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_ignore_start();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", cnt, fails);
    $finish;
  end

endmodule
